// File: rtl/uart_rx_sampler.sv
// UART receiver: 2-flop synchronized line, mid-bit sampling, 7/8 data bits, optional parity, 1/2 stop bits.
// Define UART_RX_MAJORITY_EN to take every bit as the 2-of-3 majority of samples around mid-bit.
module uart_rx_sampler (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] cr_clk_div_i,
    input  logic        cr_ds_i,
    input  logic        cr_s_i,
    input  logic [1:0]  cr_p_i,
    input  logic        uart_rx_i,
    output logic [10:0] frame_o,
    output logic        parity_err_o,
    output logic        frame_err_o,
    output logic        output_valid_o
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t      state_q;
    logic        sync1_q, sync2_q, prev_q;
    logic [15:0] cnt_q, div_q;
    logic        ds_q, s_q;
    logic [1:0]  p_q;
    logic [2:0]  bit_idx_q;
    logic [7:0]  data_q;
    logic        par_q, stop1_q;
    logic [10:0] frame_q;
    logic        parity_err_q, frame_err_q, valid_q;
`ifdef UART_RX_MAJORITY_EN
    logic [1:0]  maj_q;
`endif

    logic [15:0] half;
    logic        cnt_end, sample_hit, bit_val, fall_det, par_en, last_stop;
    logic [2:0]  last_data_idx;
    logic [10:0] frame_d;
    logic        parity_err_d, frame_err_d;

    // NOTE: every signal gets a value at the top of always_comb so no latch is inferred.
    always_comb begin
        half          = div_q >> 1;
        cnt_end       = (cnt_q == div_q - 16'd1);
        fall_det      = prev_q & ~sync2_q;
        par_en        = (p_q == 2'b01) || (p_q == 2'b10);
        last_data_idx = ds_q ? 3'd6 : 3'd7;
        // The second stop bit is sampled while bit_idx_q counts 1.
        last_stop     = ~s_q | bit_idx_q[0];
`ifdef UART_RX_MAJORITY_EN
        sample_hit    = (cnt_q == half + 16'd1);
        bit_val       = (maj_q[0] & maj_q[1]) | (maj_q[0] & sync2_q) | (maj_q[1] & sync2_q);
`else
        sample_hit    = (cnt_q == half);
        bit_val       = sync2_q;
`endif
        frame_d       = {s_q & bit_val, s_q ? stop1_q : bit_val, par_q, data_q};
        parity_err_d  = par_en & (^data_q ^ par_q ^ p_q[1]);
        frame_err_d   = s_q ? ~(stop1_q & bit_val) : ~bit_val;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            prev_q       <= 1'b1;
            cnt_q        <= '0;
            div_q        <= '0;
            ds_q         <= 1'b0;
            s_q          <= 1'b0;
            p_q          <= '0;
            bit_idx_q    <= '0;
            data_q       <= '0;
            par_q        <= 1'b0;
            stop1_q      <= 1'b0;
            frame_q      <= '0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            valid_q      <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
            maj_q        <= '0;
`endif
        end else begin
            sync1_q <= uart_rx_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            valid_q <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
            if (cnt_q == half - 16'd1) maj_q[0] <= sync2_q;
            if (cnt_q == half)         maj_q[1] <= sync2_q;
`endif
            if (state_q != IDLE) cnt_q <= cnt_end ? '0 : cnt_q + 16'd1;

            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (fall_det && cr_clk_div_i >= 16'd4) begin
                        state_q   <= START;
                        div_q     <= cr_clk_div_i;
                        ds_q      <= cr_ds_i;
                        s_q       <= cr_s_i;
                        p_q       <= cr_p_i;
                        bit_idx_q <= '0;
                        data_q    <= '0;
                        par_q     <= 1'b0;
                        stop1_q   <= 1'b0;
                    end
                end
                START: begin
                    if (sample_hit && bit_val) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_end) begin
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (sample_hit) data_q[bit_idx_q] <= bit_val;
                    if (cnt_end) begin
                        if (bit_idx_q == last_data_idx) begin
                            bit_idx_q <= '0;
                            state_q   <= par_en ? PARITY : STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end
                end
                PARITY: begin
                    if (sample_hit) par_q <= bit_val;
                    if (cnt_end) state_q <= STOP;
                end
                STOP: begin
                    // Frame completes right after the final stop sample, not at the end of the bit.
                    if (sample_hit && last_stop) begin
                        frame_q      <= frame_d;
                        parity_err_q <= parity_err_d;
                        frame_err_q  <= frame_err_d;
                        valid_q      <= 1'b1;
                        state_q      <= IDLE;
                        cnt_q        <= '0;
                        bit_idx_q    <= '0;
                    end else begin
                        if (sample_hit) stop1_q <= bit_val;
                        if (cnt_end) bit_idx_q <= bit_idx_q + 3'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign frame_o        = frame_q;
    assign parity_err_o   = parity_err_q;
    assign frame_err_o    = frame_err_q;
    assign output_valid_o = valid_q;

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Self-checking bench for uart_rx_sampler: directed frames plus random frames against a frame-level model.
module tb_uart_rx_sampler;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cr_div;
    logic        cr_ds, cr_s;
    logic [1:0]  cr_p;
    logic        rx;
    logic [10:0] frame;
    logic        perr, ferr, valid;

    int n_checks = 0;
    int n_bad    = 0;
    int pulses   = 0;
    int cyc      = 0;
    int last_pulse_cyc = 0;
    int fall_cyc = 0;

    uart_rx_sampler dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .cr_clk_div_i  (cr_div),
        .cr_ds_i       (cr_ds),
        .cr_s_i        (cr_s),
        .cr_p_i        (cr_p),
        .uart_rx_i     (rx),
        .frame_o       (frame),
        .parity_err_o  (perr),
        .frame_err_o   (ferr),
        .output_valid_o(valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid) begin
            pulses         <= pulses + 1;
            last_pulse_cyc <= cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Frame-level reference: returns {frame_err, parity_err, frame[10:0]} for the bits put on the line.
    function automatic logic [12:0] model(input bit ds, input bit s, input bit [1:0] p,
                                          input bit [7:0] data, input bit par_bit,
                                          input bit st1, input bit st2);
        int   ones;
        int   f;
        bit   pen;
        bit   pe;
        bit   fe;
        bit [7:0] d;
        d    = ds ? {1'b0, data[6:0]} : data;
        pen  = (p == 2'b01) || (p == 2'b10);
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        f = int'(d);
        if (pen && par_bit) f += 256;
        if (st1)            f += 512;
        if (s && st2)       f += 1024;
        pe = pen && (((ones + int'(par_bit)) % 2) != ((p == 2'b10) ? 1 : 0));
        fe = !st1 || (s && !st2);
        return {fe, pe, f[10:0]};
    endfunction

    // Drives one frame, each bit held div cycles; optional truncation, 1-cycle glitch and cr_* scramble.
    task automatic send(input int div, input bit ds, input bit s, input bit [1:0] p,
                        input bit [7:0] data, input bit par_bit, input bit st1, input bit st2,
                        input int nbits_max, input int glitch_bit, input bit scramble);
        bit bits[12];
        int n;
        int h;
        h = div / 2;
        n = 0;
        @(negedge clk);
        cr_div = 16'(div);
        cr_ds  = ds;
        cr_s   = s;
        cr_p   = p;
        bits[n] = 1'b0; n++;
        for (int i = 0; i < (ds ? 7 : 8); i++) begin
            bits[n] = data[i]; n++;
        end
        if (p == 2'b01 || p == 2'b10) begin
            bits[n] = par_bit; n++;
        end
        bits[n] = st1; n++;
        if (s) begin
            bits[n] = st2; n++;
        end
        if (nbits_max < n) n = nbits_max;
        for (int k = 0; k < n; k++) begin
            if (scramble && k == 1) begin
                cr_div = 16'($urandom_range(0, 40));
                cr_ds  = 1'($urandom);
                cr_s   = 1'($urandom);
                cr_p   = 2'($urandom);
            end
            for (int c = 0; c < div; c++) begin
                rx = (k == glitch_bit && c == h + 1) ? 1'b0 : bits[k];
                if (k == 0 && c == 0) fall_cyc = cyc;
                @(negedge clk);
            end
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_frame(input string tag, input int p0, input logic [12:0] exp);
        check({tag, "_pulses"}, pulses - p0, 1);
        check({tag, "_frame"}, frame, exp[10:0]);
        check({tag, "_perr"}, perr, exp[11]);
        check({tag, "_ferr"}, ferr, exp[12]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int p0;
        int div;
        bit ds, s, par_bit, st1, st2;
        bit [1:0] p;
        bit [7:0] data;

        rst = 1'b1; rx = 1'b1; cr_div = 16'd16; cr_ds = 1'b0; cr_s = 1'b0; cr_p = 2'b00;
        repeat (3) @(negedge clk);
        check("rst_frame", frame, 0);
        check("rst_perr", perr, 0);
        check("rst_ferr", ferr, 0);
        check("rst_valid", valid, 0);
        rst = 1'b0;
        idle(5);

        // 8N1 0xA5 with pulse latency from the pin falling
        p0 = pulses;
        send(16, 0, 0, 2'b00, 8'hA5, 0, 1, 0, 99, -1, 0);
        idle(20);
        expect_frame("a5_8n1", p0, {1'b0, 1'b0, 11'h2A5});
        check("a5_latency_ok", (last_pulse_cyc - fall_cyc >= 152) && (last_pulse_cyc - fall_cyc <= 158), 1);

        // 7E2 0x41, parity bit 0
        p0 = pulses;
        send(16, 1, 1, 2'b01, 8'h41, 0, 1, 1, 99, -1, 0);
        idle(20);
        expect_frame("41_7e2", p0, {1'b0, 1'b0, 11'h641});

        // 8O1 0x00, parity bit 0 -> parity error
        p0 = pulses;
        send(16, 0, 0, 2'b10, 8'h00, 0, 1, 0, 99, -1, 0);
        idle(20);
        expect_frame("00_8o1", p0, {1'b0, 1'b1, 11'h200});

        // Break: stop bit 0 then line held low
        p0 = pulses;
        send(16, 0, 0, 2'b00, 8'h55, 0, 0, 0, 99, -1, 0);
        rx = 1'b0;
        repeat (100) @(negedge clk);
        expect_frame("break", p0, {1'b1, 1'b0, 11'h055});
        idle(5);
        check("break_hold_frame", frame, 11'h055);
        p0 = pulses;
        send(16, 0, 0, 2'b00, 8'h3C, 0, 1, 0, 99, -1, 0);
        idle(20);
        expect_frame("after_break", p0, {1'b0, 1'b0, 11'h23C});

        // False start: 3 low cycles
        p0 = pulses;
        @(negedge clk);
        rx = 1'b0;
        repeat (3) @(negedge clk);
        idle(40);
        check("false_start_pulses", pulses - p0, 0);
        p0 = pulses;
        send(16, 0, 0, 2'b00, 8'h96, 0, 1, 0, 99, -1, 0);
        idle(20);
        expect_frame("after_false", p0, {1'b0, 1'b0, 11'h296});

        // Divider below 4 never starts a frame; 4 does
        p0 = pulses;
        @(negedge clk);
        cr_div = 16'd3;
        rx = 1'b0;
        repeat (40) @(negedge clk);
        idle(20);
        check("div3_pulses", pulses - p0, 0);
        p0 = pulses;
        send(4, 0, 0, 2'b00, 8'hFF, 0, 1, 0, 99, -1, 0);
        idle(10);
        expect_frame("div4", p0, {1'b0, 1'b0, 11'h2FF});

        // Reset in the middle of DATA
        p0 = pulses;
        send(16, 0, 0, 2'b00, 8'hC3, 0, 1, 0, 4, -1, 0);
        rx  = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_frame", frame, 0);
        check("midrst_perr", perr, 0);
        check("midrst_ferr", ferr, 0);
        check("midrst_valid", valid, 0);
        rst = 1'b0;
        idle(200);
        check("midrst_pulses", pulses - p0, 0);
        check("midrst_frame_after", frame, 0);
        p0 = pulses;
        send(16, 0, 0, 2'b00, 8'h5A, 0, 1, 0, 99, -1, 0);
        idle(20);
        expect_frame("after_rst", p0, {1'b0, 1'b0, 11'h25A});

        // 1-cycle low glitch at mid-bit of data bit 3
        p0 = pulses;
        send(16, 0, 0, 2'b00, 8'hFF, 0, 1, 0, 99, 4, 0);
        idle(20);
`ifdef UART_RX_MAJORITY_EN
        expect_frame("glitch", p0, {1'b0, 1'b0, 11'h2FF});
`else
        expect_frame("glitch", p0, {1'b0, 1'b0, 11'h2F7});
`endif

        // Random frames with cr_* scrambled mid-frame
        for (int t = 0; t < 14; t++) begin
            div     = int'($urandom_range(6, 24));
            ds      = 1'($urandom);
            s       = 1'($urandom);
            p       = 2'($urandom);
            data    = 8'($urandom);
            par_bit = 1'($urandom);
            st1     = ($urandom_range(0, 3) != 0);
            st2     = ($urandom_range(0, 3) != 0);
            p0 = pulses;
            send(div, ds, s, p, data, par_bit, st1, st2, 99, -1, 1);
            idle(div + 4);
            expect_frame($sformatf("rand%0d", t), p0, model(ds, s, p, data, par_bit, st1, st2));
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
